instr_encoder_loader: RTL and testbench

- Encodes structured instruction descriptors into 9-bit machine words for the core's control decoder.
- Writes the encoded words sequentially into instruction memory.
- Sits between the program source (test harness or host bridge) and instruction memory.
- Raises Loaded once the halt word (9'b011111111) is stored, so the core can be released with Start.
- Rejects descriptors the decoder would misinterpret.

---
 rtl/instr_pkg.sv | 26 ++
 rtl/instr_encode.sv | 38 +++
 rtl/instr_encoder_loader.sv | 112 +++++++++++
 tb/tb_instr_encoder_loader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// instr_pkg: shared instruction classes, opcode prefixes and error codes
package instr_pkg;
  typedef enum logic [2:0] {
    CL_ALU  = 3'd0,
    CL_CMP  = 3'd1,
    CL_BR   = 3'd2,
    CL_LDR  = 3'd3,
    CL_LDC  = 3'd4,
    CL_ST   = 3'd5,
    CL_MOV  = 3'd6,
    CL_HALT = 3'd7
  } instr_class_t;
  localparam logic [2:0] OP_BR      = 3'b100;
  localparam logic [2:0] OP_ST      = 3'b101;
  localparam logic [2:0] OP_LD      = 3'b110;
  localparam logic [2:0] OP_MOV     = 3'b111;
  localparam logic [3:0] CMP_PREFIX = 4'b0110;
  localparam logic [8:0] HALT_WORD  = 9'b011111111;
  localparam logic [2:0] ALUOP_CMP  = 3'b110;
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_FIELD    = 2'd1,
    ERR_COLLIDE  = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_code_t;
endpackage

// File: rtl/instr_encode.sv
// instr_encode: combinational descriptor-to-word encoder with legality checks
module instr_encode
  import instr_pkg::*;
(
  input  instr_class_t i_class,
  input  logic [2:0]   i_aluop,
  input  logic [2:0]   i_ra,
  input  logic [2:0]   i_rb,
  input  logic [5:0]   i_imm,
  output logic [8:0]   o_word,
  output err_code_t    o_err
);
  // Pack the fields for the class; flag anything the decoder would misread
  always_comb begin
    o_word = '0;
    o_err  = ERR_NONE;
    case (i_class)
      CL_ALU: begin
        o_word = {1'b0, i_aluop, i_ra[1:0], i_rb};
        if (i_ra[2] || i_aluop == ALUOP_CMP) o_err = ERR_FIELD;
        else if (i_aluop == 3'b111 && i_ra == 3'd3 && i_rb == 3'd7) o_err = ERR_COLLIDE;
      end
      CL_CMP: begin
        o_word = {CMP_PREFIX, i_ra[1:0], i_rb};
        o_err  = i_ra[2] ? ERR_FIELD : ERR_NONE;
      end
      CL_BR:  o_word = {OP_BR, i_imm};
      CL_LDR: o_word = {OP_LD, i_rb, 3'b000};
      CL_LDC: begin
        o_word = {OP_LD, i_imm[4:0], 1'b1};
        o_err  = i_imm[5] ? ERR_FIELD : ERR_NONE;
      end
      CL_ST:  o_word = {OP_ST, i_rb, 3'b000};
      CL_MOV: o_word = {OP_MOV, i_ra, i_rb};
      default: o_word = HALT_WORD;
    endcase
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes descriptors and streams them into instruction memory
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int IM_DEPTH  = 256,
  parameter int BASE_ADDR = 0,
  localparam int AW = $clog2(IM_DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Clear,
  input  logic          InValid,
  output logic          InReady,
  input  logic [2:0]    InClass,
  input  logic [2:0]    InAluop,
  input  logic [2:0]    InRa,
  input  logic [2:0]    InRb,
  input  logic [5:0]    InImm,
  output logic          ImWen,
  output logic [AW-1:0] ImAddr,
  output logic [8:0]    ImData,
  output logic [7:0]    Count,
  output logic          Loaded,
  output logic          Err,
  output logic [1:0]    ErrCode
);
  typedef enum logic [1:0] {IDLE, LOAD, FINISH, ERR} state_t;
  state_t       r_state, w_next;
  logic         r_wen, r_loaded, r_err;
  logic [AW-1:0] r_addr, r_ptr;
  logic [8:0]   r_data;
  logic [7:0]   r_count;
  err_code_t    r_code;
  logic [8:0]   w_word;
  err_code_t    w_enc_err, w_err;
  logic         w_acc, w_halt, w_ovf, w_write;

  instr_encode u_enc (
    .i_class (instr_class_t'(InClass)),
    .i_aluop (InAluop),
    .i_ra    (InRa),
    .i_rb    (InRb),
    .i_imm   (InImm),
    .o_word  (w_word),
    .o_err   (w_enc_err)
  );

  assign InReady = r_state == LOAD;
  assign w_acc   = InValid && InReady && !Clear;
  assign w_halt  = InClass == CL_HALT;
  assign w_ovf   = r_ptr == AW'(IM_DEPTH - 1) && !w_halt;
  assign w_write = w_acc && w_enc_err == ERR_NONE;
  assign w_err   = !w_acc ? ERR_NONE : w_enc_err != ERR_NONE ? w_enc_err : w_ovf ? ERR_OVERFLOW : ERR_NONE;

  // Next state: Clear restarts, errors and HALT park the loader until Clear
  always_comb begin
    w_next = r_state;
    if (Clear) w_next = IDLE;
    else if (r_state == IDLE) w_next = LOAD;
    else if (r_state == LOAD && w_acc)
      w_next = w_err != ERR_NONE ? ERR : w_halt ? FINISH : LOAD;
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  // Write port, address pointer, counters and sticky flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wen    <= 1'b0;
      r_addr   <= AW'(BASE_ADDR);
      r_ptr    <= AW'(BASE_ADDR);
      r_data   <= '0;
      r_count  <= '0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= ERR_NONE;
    end else if (Clear) begin
      r_wen    <= 1'b0;
      r_addr   <= AW'(BASE_ADDR);
      r_ptr    <= AW'(BASE_ADDR);
      r_count  <= '0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= ERR_NONE;
    end else begin
      r_wen <= w_write;
      if (w_write) begin
        r_addr  <= r_ptr;
        r_data  <= w_word;
        r_ptr   <= r_ptr + AW'(1);
        r_count <= r_count == 8'hFF ? r_count : r_count + 8'd1;
        if (w_halt) r_loaded <= 1'b1;
      end
      if (w_err != ERR_NONE && !r_err) begin
        r_err  <= 1'b1;
        r_code <= w_err;
      end
    end
  end

  assign ImWen   = r_wen;
  assign ImAddr  = r_addr;
  assign ImData  = r_data;
  assign Count   = r_count;
  assign Loaded  = r_loaded;
  assign Err     = r_err;
  assign ErrCode = r_code;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed plus random checks of two loaders against a reference model
module tb_instr_encoder_loader;
  logic Clk = 0, Reset_n = 1, Clear = 0, InValid = 0;
  logic [2:0] InClass = 0, InAluop = 0, InRa = 0, InRb = 0;
  logic [5:0] InImm = 0;
  logic rdy0, wen0, ld0, err0, rdy1, wen1, ld1, err1;
  logic [7:0] addr0, cnt0, cnt1;
  logic [1:0] addr1, code0, code1;
  logic [8:0] data0, data1;
  int n_chk = 0, n_pass = 0;
  int dep [2] = '{256, 4};
  int m_ph [2], m_nx [2], m_addr [2], m_cnt [2], m_code [2];
  bit m_wen [2], m_ld [2], m_err [2];
  logic [8:0] m_data [2];

  always #5 Clk = ~Clk;

  instr_encoder_loader u0 (.Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .InValid(InValid), .InReady(rdy0),
    .InClass(InClass), .InAluop(InAluop), .InRa(InRa), .InRb(InRb), .InImm(InImm), .ImWen(wen0),
    .ImAddr(addr0), .ImData(data0), .Count(cnt0), .Loaded(ld0), .Err(err0), .ErrCode(code0));

  instr_encoder_loader #(.IM_DEPTH(4)) u1 (.Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .InValid(InValid), .InReady(rdy1),
    .InClass(InClass), .InAluop(InAluop), .InRa(InRa), .InRb(InRb), .InImm(InImm), .ImWen(wen1),
    .ImAddr(addr1), .ImData(data1), .Count(cnt1), .Loaded(ld1), .Err(err1), .ErrCode(code1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Returns {error code, word} straight from the encoding table and legality rules
  function automatic logic [10:0] ref_enc(input int c, input int op, input int ra, input int rb, input int im);
    int w, e;
    e = 0;
    case (c)
      0: begin w = op * 32 + (ra % 4) * 8 + rb; e = (ra >= 4 || op == 6) ? 1 : (op == 7 && ra == 3 && rb == 7) ? 2 : 0; end
      1: begin w = 6 * 32 + (ra % 4) * 8 + rb; e = ra >= 4 ? 1 : 0; end
      2: w = 256 + im;
      3: w = 384 + rb * 8;
      4: begin w = 384 + (im % 32) * 2 + 1; e = im >= 32 ? 1 : 0; end
      5: w = 320 + rb * 8;
      6: w = 448 + ra * 8 + rb;
      default: w = 255;
    endcase
    return {2'(e), 9'(w)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_nx[i] = 0; m_addr[i] = 0; m_cnt[i] = 0; m_code[i] = 0;
      m_wen[i] = 0; m_ld[i] = 0; m_err[i] = 0; m_data[i] = 0;
    end
  endtask

  // m_ph: 0 starting up, 1 accepting, 2 stopped (halted or errored)
  task automatic model_edge();
    logic [10:0] r;
    for (int i = 0; i < 2; i++) begin
      m_wen[i] = 0;
      if (Clear) begin
        m_ph[i] = 0; m_nx[i] = 0; m_addr[i] = 0; m_cnt[i] = 0; m_ld[i] = 0; m_err[i] = 0; m_code[i] = 0;
      end else if (m_ph[i] == 0) m_ph[i] = 1;
      else if (m_ph[i] == 1 && InValid) begin
        r = ref_enc(int'(InClass), int'(InAluop), int'(InRa), int'(InRb), int'(InImm));
        if (r[10:9] != 0) begin m_err[i] = 1; m_code[i] = int'(r[10:9]); m_ph[i] = 2; end
        else begin
          m_wen[i] = 1; m_addr[i] = m_nx[i]; m_data[i] = r[8:0];
          m_nx[i] = (m_nx[i] + 1) % dep[i];
          m_cnt[i] = m_cnt[i] < 255 ? m_cnt[i] + 1 : 255;
          if (InClass == 7) begin m_ld[i] = 1; m_ph[i] = 2; end
          else if (m_addr[i] == dep[i] - 1) begin m_err[i] = 1; m_code[i] = 3; m_ph[i] = 2; end
        end
      end
    end
  endtask

  task automatic compare();
    chk("rdy0", rdy0, m_ph[0] == 1);   chk("rdy1", rdy1, m_ph[1] == 1);
    chk("wen0", wen0, m_wen[0]);       chk("wen1", wen1, m_wen[1]);
    chk("addr0", addr0, m_addr[0]);    chk("addr1", addr1, m_addr[1]);
    chk("data0", data0, m_data[0]);    chk("data1", data1, m_data[1]);
    chk("cnt0", cnt0, m_cnt[0]);       chk("cnt1", cnt1, m_cnt[1]);
    chk("ld0", ld0, m_ld[0]);          chk("ld1", ld1, m_ld[1]);
    chk("err0", err0, m_err[0]);       chk("err1", err1, m_err[1]);
    chk("code0", code0, m_code[0]);    chk("code1", code1, m_code[1]);
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_edge();
    #1 compare();
  endtask

  task automatic send(input int c, input int op, input int ra, input int rb, input int im);
    InValid = 1; InClass = 3'(c); InAluop = 3'(op); InRa = 3'(ra); InRb = 3'(rb); InImm = 6'(im);
    cyc();
    InValid = 0;
  endtask

  task automatic restart();
    Clear = 1; cyc(); Clear = 0; cyc();
  endtask

  logic [8:0] words [5] = '{9'b100101010, 9'b110100111, 9'b111100010, 9'b101011000, 9'b110110000};

  initial begin
    #1 Reset_n = 0;
    #2 model_reset();
    compare();
    @(negedge Clk) Reset_n = 1;
    cyc();
    send(0, 2, 1, 5, 0);
    chk("alu_wen", wen0, 1); chk("alu_addr", addr0, 0); chk("alu_word", data0, 9'b001001101);
    cyc();
    restart();
    send(2, 0, 0, 0, 6'h2A); chk("br_word", data0, words[0]);
    send(4, 0, 0, 0, 6'h13); chk("ldc_word", data0, words[1]);
    send(6, 0, 4, 2, 0);     chk("mov_word", data0, words[2]);
    send(5, 0, 0, 3, 0);     chk("st_word", data0, words[3]);
    send(3, 0, 0, 6, 0);     chk("ldr_word", data0, words[4]); chk("ldr_addr", addr0, 4); chk("stream_rdy", rdy0, 1);
    restart();
    send(1, 0, 2, 1, 0);     chk("cmp_word", data0, 9'b011010001);
    send(7, 0, 0, 0, 0);     chk("halt_word", data0, 9'b011111111);
    cyc(); chk("halt_ld", ld0, 1); chk("halt_rdy", rdy0, 0); chk("halt_cnt", cnt0, 2);
    restart();
    send(0, 7, 3, 7, 0);     chk("coll_wen", wen0, 0); chk("coll_err", err0, 1); chk("coll_code", code0, 2);
    send(0, 6, 0, 0, 0);     chk("coll_keep", code0, 2);
    Clear = 1; cyc(); Clear = 0;
    chk("clr_err", err0, 0); chk("clr_addr", addr0, 0);
    cyc();
    for (int k = 0; k < 4; k++) send(0, 0, 1, 1, 0);
    chk("ovf_addr", addr1, 3); chk("ovf_wen", wen1, 1); chk("ovf_err", err1, 1); chk("ovf_code", code1, 3);
    restart();
    for (int k = 0; k < 3; k++) send(0, 0, 1, 1, 0);
    send(7, 0, 0, 0, 0);
    chk("lasthalt_ld", ld1, 1); chk("lasthalt_err", err1, 0); chk("lasthalt_addr", addr1, 3);
    restart();
    send(6, 0, 1, 1, 0);
    InValid = 1;
    @(posedge Clk); model_edge(); #1 compare();
    #2 Reset_n = 0;
    #1 chk("arst_wen", wen0, 0); chk("arst_cnt", cnt0, 0); chk("arst_rdy", rdy0, 0); chk("arst_data", data0, 0);
    model_reset(); compare();
    InValid = 0;
    @(negedge Clk) Reset_n = 1;
    cyc();
    Clear = 1; InValid = 1; InClass = 3'd6; InRa = 3'd2; InRb = 3'd2;
    cyc(); chk("clr_drop", wen0, 0);
    Clear = 0; InValid = 0;
    cyc();
    for (int k = 0; k < 256; k++) send(6, 0, k % 8, 1, 0);
    chk("sat_cnt", cnt0, 255); chk("sat_addr", addr0, 255); chk("sat_code", code0, 3);
    for (int n = 0; n < 1500; n++) begin
      Clear = (m_ph[0] == 2 && m_ph[1] == 2) || ($urandom % 50 == 0);
      InValid = ($urandom % 4) != 0;
      InClass = 3'($urandom); InAluop = 3'($urandom); InRb = 3'($urandom); InImm = 6'($urandom);
      InRa = ($urandom % 4 == 0) ? 3'($urandom) : 3'($urandom % 4);
      cyc();
    end
    Clear = 0; InValid = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
